// File: rtl/interp_pkg.sv
// rtl/interp_pkg.sv - shared types and constants for the interpolation scheduler
package interp_pkg;

    // Default operand/result width: Q.7 min/max, Q.14 gradient
    localparam int W_DEFAULT = 16;

    // 1.0 in Q.14
    localparam logic [15:0] Q14_ONE = 16'h4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin picker starting at rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // Walk offsets from farthest to nearest so the requester closest to rr_ptr wins
    always_comb begin
        logic [IDX_W:0] cand;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (IDX_W + 1)'(k);
            if (cand >= (IDX_W + 1)'(NUM_REQ)) begin
                cand = cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (req[cand[IDX_W-1:0]]) begin
                grant                    = '0;
                grant[cand[IDX_W-1:0]]   = 1'b1;
                grant_idx                = cand[IDX_W-1:0];
                grant_valid              = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interp_sched.sv
// rtl/interp_sched.sv - round-robin sharing of one interpolator; optional INTERP_SCHED_CLAMP_BYPASS_EN
module interp_sched
    import interp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int W       = W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*W-1:0] req_min,
    input  logic [NUM_REQ*W-1:0] req_max,
    input  logic [NUM_REQ*W-1:0] req_grad,
    output logic [NUM_REQ-1:0]   ack,
    output logic [W-1:0]         res_val,
    output logic                 busy,
    output logic                 interp_start,
    output logic [W-1:0]         interp_min,
    output logic [W-1:0]         interp_max,
    output logic [W-1:0]         interp_grad,
    input  logic                 interp_done,
    input  logic [W-1:0]         interp_val
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t       state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant_idx;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;

    logic [W-1:0]       win_min;
    logic [W-1:0]       win_max;
    logic [W-1:0]       win_grad;

    logic               bypass;
    logic [W-1:0]       bypass_val;

    // Pointer to the requester after idx, wrapping at NUM_REQ-1
    function automatic logic [IDX_W-1:0] ptr_after(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    endfunction

    // One-hot ack vector for a recorded grant index
    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req         (req),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign win_min  = req_min[arb_idx*W +: W];
    assign win_max  = req_max[arb_idx*W +: W];
    assign win_grad = req_grad[arb_idx*W +: W];

`ifdef INTERP_SCHED_CLAMP_BYPASS_EN
    // Out-of-range gradients clamp to an endpoint without using the interpolator
    logic win_neg;
    logic win_sat;
    assign win_neg    = win_grad[W-1];
    assign win_sat    = !win_grad[W-1] && (win_grad >= W'(Q14_ONE));
    assign bypass     = win_neg | win_sat;
    assign bypass_val = win_neg ? win_min : win_max;
`else
    assign bypass     = 1'b0;
    assign bypass_val = '0;
`endif

    // Scheduler FSM: grant in IDLE, hold start in ISSUE, wait for done release in DRAIN
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_idx    <= '0;
            ack          <= '0;
            res_val      <= '0;
            busy         <= 1'b0;
            interp_start <= 1'b0;
            interp_min   <= '0;
            interp_max   <= '0;
            interp_grad  <= '0;
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    // A pending ack means its requester may still show req; never re-grant then
                    if (arb_valid && (ack == '0)) begin
                        grant_idx <= arb_idx;
                        if (bypass) begin
                            ack     <= arb_grant;
                            res_val <= bypass_val;
                            rr_ptr  <= ptr_after(arb_idx);
                        end else begin
                            interp_min   <= win_min;
                            interp_max   <= win_max;
                            interp_grad  <= win_grad;
                            interp_start <= 1'b1;
                            busy         <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (interp_done) begin
                        res_val      <= interp_val;
                        ack          <= idx_onehot(grant_idx);
                        interp_start <= 1'b0;
                        rr_ptr       <= ptr_after(grant_idx);
                        state        <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Operands stay put until the interpolator has dropped done
                    if (!interp_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy         <= 1'b0;
                    interp_start <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/interp_sched.md
Name: interp_sched

Overview:
- Round-robin scheduler that shares one Q.7/Q.14 interpolation unit among NUM_REQ attribute requesters (e.g. R, G, B, Z per pixel).
- Owns the unit's start/done handshake: latches a winner's operands, drives start, captures val, returns the result with a one-cycle ack.
- Sits between the per-attribute shading front end and the single interpolator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- W, 16, operand/result width (min/max Q.7, gradient Q.14).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- req  in  NUM_REQ  request level per requester; held until its ack.
- req_min  in  NUM_REQ*W  packed min_val per requester, Q.7.
- req_max  in  NUM_REQ*W  packed max_val per requester, Q.7.
- req_grad  in  NUM_REQ*W  packed gradient per requester, Q.14.
- ack  out  NUM_REQ  one-hot, one-cycle pulse: result valid for that requester.
- res_val  out  W  result, valid while any ack bit is high.
- busy  out  1  high whenever state is not IDLE.
- interp_start  out  1  start to the interpolator.
- interp_min, interp_max, interp_grad  out  W each  operands to the interpolator; held stable while interp_start is high.
- interp_done  in  1  done from the interpolator.
- interp_val  in  W  result from the interpolator.

Behaviour:
- Reset values: ack=0, res_val=0, interp_start=0, interp_min/max/grad=0, busy=0, state=IDLE, rr_ptr=0.
- States:
  - IDLE: if any req bit is set, pick a winner round-robin, starting the search at rr_ptr and wrapping at NUM_REQ-1. Latch its three operands into the interp_* registers, record the grant index, and go to ISSUE. No req bits: stay in IDLE.
  - ISSUE: interp_start=1. Stay until interp_done=1, then:
    - res_val <= interp_val;
    - ack[grant] pulses for one cycle;
    - interp_start <= 0;
    - rr_ptr <= grant+1 (wrap to 0);
    - go to DRAIN.
  - DRAIN: interp_start=0. Stay until interp_done=0, then return to IDLE. Operands do not change until interp_done is observed low, so the unit returns to its idle state first.
- Latency: with the current interpolator, req to ack is 6 cycles. The scheduler itself must not assume a fixed latency.
- Throughput: at most one grant in flight. A new grant is never issued in the same cycle as an ack.
- Requesters:
  - A requester dropping req while granted is ignored; its result is still produced and acked.
  - ack goes only to the requester granted in IDLE. req changes after the grant do not redirect it.
- Fairness: with all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0.
- interp_done=1 while in IDLE is ignored.
- Reset mid-operation: returns to IDLE the next cycle, drops interp_start, and produces no ack. The interpolator is reset by the same signal.

Optional Feature:
- Macro: INTERP_SCHED_CLAMP_BYPASS_EN.
- Defined: in IDLE, if the winner's grad[W-1]=1 (negative) or grad >= 0x4000 (>= 1.0), the interpolator is not started.
  - Next cycle: res_val = min (negative case) or max (>= 1.0 case), ack[grant] pulses, rr_ptr advances, state stays in IDLE.
  - Bypass latency is 1 cycle from grant; busy stays 0.
- Undefined: all grants go through ISSUE/DRAIN.

Decomposition:
- Package interp_pkg:
  - state enum sched_state_t {IDLE, ISSUE, DRAIN};
  - constant Q14_ONE = 16'h4000;
  - W default.
- One sub-module: rr_arbiter (NUM_REQ request vector and rr_ptr in, one-hot grant plus index out, combinational).
- Scheduler FSM and operand registers stay in interp_sched.
- Bench instantiates interp_sched together with the real interpolator.

Test Plan:
1. Single request: req=0001, min=0x0100, max=0x0300, grad=0x2000 -> one ack=0001 pulse with res_val=0x0200; interp_start high for exactly the ISSUE cycles; busy falls after DRAIN.
2. All four requesters held with distinct operands -> acks in order 0,1,2,3,0; each res_val matches that requester's expected interpolation; no two starts without a DRAIN between them.
3. Requester 2 drops req while in ISSUE -> ack[2] still pulses with the correct value, then requester 3 is granted next.
4. reset asserted in ISSUE -> next cycle interp_start=0, ack=0, busy=0; a subsequent req=0001 is served starting at index 0.
5. Negative gradient, req=0001, min=0x0080, max=0x0200, grad=0xC000:
   - with INTERP_SCHED_CLAMP_BYPASS_EN: ack 1 cycle after grant, res_val=0x0080, interp_start never rises;
   - without it: res_val=0x0080 via the interpolator.
6. Stuck interp_done=1 held in IDLE with no req -> no ack, no start; then req=0100 -> granted and acked normally once done toggles.
